branch_recovery_ctrl: RTL
=========================

Name: branch_recovery_ctrl

Overview:
- Consumer end of the branch functional unit's resolution interface.
- Samples each resolved branch/JALR result and, on a mispredict, sequences pipeline recovery in order: flush broadcast to ROB/RS/LSQ, rename-checkpoint restore handshake, then fetch redirect.
- Arbitrates overlapping mispredicts by ROB age and stalls dispatch while recovery is in progress.

Parameters:
ROB_DEPTH, 32, ROB entries; TAG_W = $clog2(ROB_DEPTH)
PC_W, 32, PC / target width
CNT_W, 16, mispredict performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
br_done  in  1  branch FU result valid this cycle
br_mispredict  in  1  resolved direction/target differs from prediction (qualified by br_done)
br_tag  in  TAG_W  ROB index of resolving branch
br_target  in  PC_W  correct next PC
rob_head  in  TAG_W  current ROB head index, for age compare
flush_valid  out  1  one-cycle flush pulse
flush_tag  out  TAG_W  squash all entries younger than this tag
restore_req  out  1  request rename/freelist checkpoint restore
restore_tag  out  TAG_W  checkpoint to restore
restore_ack  in  1  restore complete, single-cycle pulse
redirect_valid  out  1  fetch redirect request
redirect_pc  out  PC_W  redirect target
redirect_ready  in  1  fetch accepts redirect
busy  out  1  recovery in progress; dispatch stalls
mispredict_cnt  out  CNT_W  saturating count of accepted mispredicts

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; stored tag and PC 0; mispredict_cnt 0.
- Event: br_done & br_mispredict sampled at posedge. If br_done=1 and br_mispredict=0, nothing happens (correct prediction).
- Age: age(t) = (t - rob_head) mod ROB_DEPTH. Smaller age = older.
- States: IDLE, FLUSH, RESTORE, REDIRECT.
- IDLE: on event, latch tag/target, increment counter, go to FLUSH.
- FLUSH: flush_valid=1 for exactly this cycle; flush_tag=latched tag. Next state RESTORE.
- RESTORE: restore_req=1 with restore_tag held until restore_ack is sampled. On ack, go to REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc held stable until redirect_valid & redirect_ready is sampled. Then go to IDLE.
- Latency: event at edge N gives flush_valid during cycle N+1 and restore_req from cycle N+2. With restore_ack at edge N+2, redirect_valid is asserted in cycle N+3. With ready already high, the controller is back in IDLE in cycle N+4.
- busy=1 in every state except IDLE, including the cycle flush_valid is high.
- Event while not IDLE:
  - age(br_tag) < age(latched tag), i.e. older: re-latch tag/target, increment counter, go to FLUSH. Any pending restore or redirect is abandoned.
  - Younger or equal age: ignore the event. It is already squashed; the counter does not change.
- restore_ack outside RESTORE is ignored. redirect_ready outside REDIRECT is ignored.
- Counter saturates at 2^CNT_W-1 (no wrap).
- Event in the same cycle as the return to IDLE (REDIRECT handshake completes): the event is accepted as a new recovery; next state is FLUSH.
- Reset asserted mid-recovery aborts immediately: all outputs go to 0.

Test Plan:
- Reset: hold reset=0 two cycles, release -> busy=0, flush_valid=0, redirect_valid=0, mispredict_cnt=0.
- Basic recovery: rob_head=0; br_done=1, br_mispredict=1, br_tag=12, br_target=2100. Pulse restore_ack one cycle after restore_req rises; redirect_ready=1.
  -> flush_valid single cycle with flush_tag=12.
  -> restore_tag=12.
  -> redirect_pc=2100 for one cycle.
  -> busy high for 4 cycles, cnt=1.
- Correct prediction: br_done=1, br_mispredict=0, tag=5 -> no output activity, busy=0, cnt unchanged.
- Older overrides younger: rob_head=10; mispredict tag=20 target=0x400. While in RESTORE, mispredict tag=15 target=0x300 arrives.
  -> second flush_valid with tag 15.
  -> final redirect_pc=0x300.
  -> cnt=2.
- Younger ignored, with wrap-around: rob_head=30; mispredict tag=1 (age 3). During RESTORE, mispredict tag=4 (age 6) arrives.
  -> no second flush; redirect_pc = tag-1 target; cnt=1.
- Backpressure and reset abort:
  - redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stay stable; ready=1 -> IDLE next cycle.
  - Repeat the sequence and assert reset=0 during RESTORE -> restore_req and busy drop immediately, no redirect follows.

Source files
------------

// File: rtl/branch_recovery_ctrl_if.sv
// Branch resolution / pipeline recovery bundle between the branch FU side and the recovery controller.
// The slave modport is the controller, the master modport is the surrounding pipeline.
interface branch_recovery_ctrl_if #(
    parameter int ROB_DEPTH = 32,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 16
);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    logic             br_done;
    logic             br_mispredict;
    logic [TAG_W-1:0] br_tag;
    logic [PC_W-1:0]  br_target;
    logic [TAG_W-1:0] rob_head;
    logic             flush_valid;
    logic [TAG_W-1:0] flush_tag;
    logic             restore_req;
    logic [TAG_W-1:0] restore_tag;
    logic             restore_ack;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             busy;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output br_done, br_mispredict, br_tag, br_target, rob_head,
        output restore_ack, redirect_ready,
        input  flush_valid, flush_tag, restore_req, restore_tag,
        input  redirect_valid, redirect_pc, busy, mispredict_cnt
    );

    modport slave (
        input  br_done, br_mispredict, br_tag, br_target, rob_head,
        input  restore_ack, redirect_ready,
        output flush_valid, flush_tag, restore_req, restore_tag,
        output redirect_valid, redirect_pc, busy, mispredict_cnt
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Mispredict recovery sequencer: flush broadcast, checkpoint restore handshake, fetch redirect.
// An older mispredict arriving mid-recovery restarts the sequence; younger ones are already squashed.
module branch_recovery_ctrl #(
    parameter int ROB_DEPTH = 32,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_recovery_ctrl_if.slave bus
);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {IDLE, FLUSH, RESTORE, REDIRECT} state_t;

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic [PC_W-1:0]  pc_q;
    logic             flush_q;
    logic             restore_q;
    logic             redirect_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic             mis_event;
    logic             older;
    logic             accept;

    // Distance from the ROB head, valid for non-power-of-two depths as well.
    function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
        if (t >= h)
            age = t - h;
        else
            age = TAG_W'(ROB_DEPTH - int'(h) + int'(t));
    endfunction

    always_comb begin
        mis_event = bus.br_done & bus.br_mispredict;
        older     = age(bus.br_tag, bus.rob_head) < age(tag_q, bus.rob_head);
        accept    = 1'b0;
        case (state)
            IDLE:     accept = mis_event;
            // A completing redirect frees the controller, so any mispredict that cycle starts afresh.
            REDIRECT: accept = mis_event & (older | bus.redirect_ready);
            default:  accept = mis_event & older;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tag_q      <= '0;
            pc_q       <= '0;
            flush_q    <= 1'b0;
            restore_q  <= 1'b0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            state      <= FLUSH;
            tag_q      <= bus.br_tag;
            pc_q       <= bus.br_target;
            flush_q    <= 1'b1;
            restore_q  <= 1'b0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b1;
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            case (state)
                FLUSH: begin
                    state     <= RESTORE;
                    flush_q   <= 1'b0;
                    restore_q <= 1'b1;
                end
                RESTORE: begin
                    if (bus.restore_ack) begin
                        state      <= REDIRECT;
                        restore_q  <= 1'b0;
                        redirect_q <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state      <= IDLE;
                        redirect_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.flush_valid    = flush_q;
    assign bus.flush_tag      = tag_q;
    assign bus.restore_req    = restore_q;
    assign bus.restore_tag    = tag_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.busy           = busy_q;
    assign bus.mispredict_cnt = cnt_q;
endmodule
